// File: rtl/fact_arbiter.sv
// Round-robin arbiter sharing one factorial engine between two requesters.
// One transaction at a time; a watchdog forces completion if the engine never answers.
module fact_arbiter #(
    parameter int unsigned N_W            = 4,
    parameter int unsigned RES_W          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             req0,
    input  logic [N_W-1:0]   n0,
    input  logic             req1,
    input  logic [N_W-1:0]   n1,
    output logic             ack0,
    output logic             ack1,
    output logic [RES_W-1:0] result,
    output logic             error,
    output logic             timeout,
    output logic             busy,
    output logic             gnt_id,
    output logic             fact_go,
    output logic [N_W-1:0]   fact_n,
    input  logic             fact_done,
    input  logic             fact_error,
    input  logic [RES_W-1:0] fact_result
);

    localparam int unsigned WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StBusy, StResp} state_t;

    state_t          state;
    logic            ptr;
    logic [WD_W-1:0] watchdog;
    logic            any_req;
    logic            pick;

    // On a tie the pointer decides; otherwise the lone requester wins.
    always_comb begin
        any_req = req0 | req1;
        if (req0 && req1) begin
            pick = ptr;
        end else begin
            pick = req1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= StIdle;
            ptr      <= 1'b0;
            watchdog <= '0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            result   <= '0;
            error    <= 1'b0;
            timeout  <= 1'b0;
            busy     <= 1'b0;
            gnt_id   <= 1'b0;
            fact_go  <= 1'b0;
            fact_n   <= '0;
        end else begin
            fact_go <= 1'b0;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (any_req) begin
                        gnt_id  <= pick;
                        fact_n  <= pick ? n1 : n0;
                        error   <= 1'b0;
                        timeout <= 1'b0;
                        fact_go <= 1'b1;
                        busy    <= 1'b1;
                        state   <= StIssue;
                    end
                end
                StIssue: begin
                    watchdog <= '0;
                    state    <= StBusy;
                end
                StBusy: begin
                    watchdog <= watchdog + WD_W'(1);
                    // A done arriving on the expiry cycle still counts as a real answer.
                    if (fact_done) begin
                        result  <= fact_result;
                        error   <= fact_error;
                        timeout <= 1'b0;
                        ack0    <= ~gnt_id;
                        ack1    <= gnt_id;
                        state   <= StResp;
                    end else if (watchdog == WD_LAST) begin
                        result  <= '0;
                        error   <= 1'b1;
                        timeout <= 1'b1;
                        ack0    <= ~gnt_id;
                        ack1    <= gnt_id;
                        state   <= StResp;
                    end
                end
                StResp: begin
                    ptr   <= ~gnt_id;
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fact_arbiter.sv
// Randomised bench for fact_arbiter: a transaction-level model predicts grants, ack timing
// and results per cycle, with a few directed scenarios pinned to literal values.
module tb_fact_arbiter;

    localparam int T = 64;

    logic        CLK = 1'b0;
    logic        RST;
    logic        req0, req1;
    logic [3:0]  n0, n1;
    logic        ack0, ack1;
    logic [31:0] result;
    logic        error, timeout, busy, gnt_id, fact_go;
    logic [3:0]  fact_n;
    logic        fact_done, fact_error;
    logic [31:0] fact_result;

    always #5 CLK = ~CLK;

    fact_arbiter #(.N_W(4), .RES_W(32), .TIMEOUT_CYCLES(T)) dut (
        .CLK(CLK), .RST(RST),
        .req0(req0), .n0(n0), .req1(req1), .n1(n1),
        .ack0(ack0), .ack1(ack1), .result(result), .error(error), .timeout(timeout),
        .busy(busy), .gnt_id(gnt_id), .fact_go(fact_go), .fact_n(fact_n),
        .fact_done(fact_done), .fact_error(fact_error), .fact_result(fact_result)
    );

    int total = 0, bad = 0, cyc = 0;

    // Transaction-level model state.
    bit          in_txn = 0;
    int          go_cyc, ack_cyc, done_cyc, free_at = 0;
    bit          m_id, m_ptr = 0, m_gnt = 0;
    logic [3:0]  m_n;
    logic [31:0] m_res = '0, e_res;
    bit          e_err, e_to;

    // Stimulus knobs.
    bit pend0 = 0, pend1 = 0, allow0 = 0, allow1 = 0, stray = 0;
    int p_req = 100, p_rereq = 0, force_d = -1, force_n0 = -1, force_n1 = -1;

    // Observed transactions, recorded from DUT outputs.
    int          obs_go = 0;
    int          q_id[$], q_lat[$];
    logic [31:0] q_res[$];
    bit          q_err[$], q_to[$];

    function automatic logic [31:0] fact(input logic [3:0] n);
        logic [31:0] r;
        r = 32'd1;
        for (int i = 2; i <= int'(n); i++) r = r * 32'(i);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [3:0] pick_n(input int fn);
        if (fn >= 0) return 4'(fn);
        return 4'($urandom_range(15));
    endfunction

    task automatic drive_req(inout logic r, inout logic [3:0] n, inout bit pend,
                             input bit allow, input int fn);
        if (pend) begin
            pend = 0;
            if (allow && $urandom_range(99) < p_rereq) n = pick_n(fn);
            else r = 1'b0;
        end else if (!r && allow && $urandom_range(99) < p_req) begin
            r = 1'b1;
            n = pick_n(fn);
        end
    endtask

    task automatic step();
        int d;
        bit id;
        @(posedge CLK);
        #1;
        cyc++;
        if (in_txn && cyc == ack_cyc) m_res = e_res;
        if (fact_go) obs_go = cyc;
        chk("busy", busy, in_txn && cyc >= go_cyc && cyc <= ack_cyc);
        chk("fact_go", fact_go, in_txn && cyc == go_cyc);
        chk("ack0", ack0, in_txn && cyc == ack_cyc && !m_id);
        chk("ack1", ack1, in_txn && cyc == ack_cyc && m_id);
        chk("gnt_id", gnt_id, m_gnt);
        chk("result", result, m_res);
        if (ack0 || ack1) begin
            q_id.push_back(int'(ack1));
            q_res.push_back(result);
            q_err.push_back(error);
            q_to.push_back(timeout);
            q_lat.push_back(cyc - obs_go);
        end
        if (in_txn && cyc == go_cyc) chk("fact_n", fact_n, m_n);
        if (in_txn && cyc == ack_cyc) begin
            chk("error", error, e_err);
            chk("timeout", timeout, e_to);
            m_ptr   = ~m_id;
            in_txn  = 0;
            free_at = cyc + 1;
            if (m_id) pend1 = 1;
            else pend0 = 1;
        end
        drive_req(req0, n0, pend0, allow0, force_n0);
        drive_req(req1, n1, pend1, allow1, force_n1);
        if (!in_txn && cyc >= free_at && (req0 || req1)) begin
            id     = (req0 && req1) ? m_ptr : req1;
            m_id   = id;
            m_gnt  = id;
            m_n    = id ? n1 : n0;
            go_cyc = cyc + 1;
            if (force_d >= 0) d = force_d;
            else d = ($urandom_range(19) == 0) ? T + 3 : int'($urandom_range(6));
            if (d <= T - 1) begin
                done_cyc = cyc + 2 + d;
                ack_cyc  = done_cyc + 1;
                e_res    = fact(m_n);
                e_err    = (m_n > 4'd12);
                e_to     = 0;
            end else begin
                done_cyc = -1;
                ack_cyc  = cyc + 2 + T;
                e_res    = '0;
                e_err    = 1;
                e_to     = 1;
            end
            in_txn = 1;
        end
        if (in_txn && cyc == done_cyc) begin
            fact_done   = 1'b1;
            fact_result = fact(m_n);
            fact_error  = (m_n > 4'd12);
        end else if (stray && !(in_txn && cyc > go_cyc && cyc < ack_cyc)
                     && $urandom_range(3) == 0) begin
            fact_done   = 1'b1;
            fact_result = $urandom;
            fact_error  = 1'($urandom_range(1));
        end else begin
            fact_done   = 1'b0;
            fact_result = $urandom;
            fact_error  = 1'b0;
        end
    endtask

    task automatic run_until(input int k, input int budget);
        int n = 0;
        while (q_id.size() < k && n < budget) begin
            step();
            n++;
        end
        chk("ack_count", q_id.size(), k);
    endtask

    task automatic drain();
        int n = 0;
        allow0 = 0;
        allow1 = 0;
        while ((in_txn || req0 || req1) && n < 1000) begin
            step();
            n++;
        end
        chk("drain", {in_txn, req0, req1}, 3'b000);
        repeat (2) step();
    endtask

    task automatic model_reset();
        in_txn  = 0;
        m_ptr   = 0;
        m_gnt   = 0;
        m_res   = '0;
        free_at = 0;
        pend0   = 0;
        pend1   = 0;
    endtask

    int b;

    initial begin
        RST = 1'b1;
        req0 = 0; req1 = 0; n0 = '0; n1 = '0;
        fact_done = 0; fact_error = 0; fact_result = '0;
        repeat (2) @(negedge CLK);
        chk("rst_busy", busy, 0);
        chk("rst_acks", {ack0, ack1}, 0);
        chk("rst_out", {result, error, timeout, gnt_id, fact_go, fact_n}, 0);
        RST = 1'b0;

        // Tie straight after reset: pointer starts at requester 0.
        b = q_id.size(); force_n0 = 3; force_n1 = 4; force_d = -1;
        allow0 = 1; allow1 = 1;
        run_until(b + 2, 200);
        drain();
        chk("tie_id0", q_id[b], 0);   chk("tie_res0", q_res[b], 6);
        chk("tie_id1", q_id[b+1], 1); chk("tie_res1", q_res[b+1], 24);

        // Single request, engine latency 3.
        b = q_id.size(); force_n0 = 5; force_d = 3; allow0 = 1;
        run_until(b + 1, 100);
        drain();
        chk("one_id", q_id[b], 0);  chk("one_res", q_res[b], 120);
        chk("one_err", {q_err[b], q_to[b]}, 0); chk("one_lat", q_lat[b], 5);

        // Fairness: pointer is 1 after the last grant to 0, so 1 leads.
        b = q_id.size(); force_n0 = -1; force_n1 = -1; force_d = -1; p_rereq = 100;
        allow0 = 1; allow1 = 1;
        run_until(b + 6, 2000);
        p_rereq = 0;
        drain();
        for (int i = 0; i < 6; i++) chk("fair_id", q_id[b+i], (i % 2 == 0) ? 1 : 0);

        // Engine error passes through.
        b = q_id.size(); force_n1 = 13; force_d = 1; allow1 = 1;
        run_until(b + 1, 100);
        drain();
        chk("err_id", q_id[b], 1); chk("err_flags", {q_err[b], q_to[b]}, 2'b10);

        // Hung engine, then a normal transaction, then done on the expiry cycle.
        b = q_id.size(); force_n0 = 9; force_d = 1000; allow0 = 1;
        run_until(b + 1, 200);
        drain();
        chk("wd_res", q_res[b], 0); chk("wd_flags", {q_err[b], q_to[b]}, 2'b11);
        chk("wd_lat", q_lat[b], 65);
        b = q_id.size(); force_n0 = 4; force_d = 2; allow0 = 1;
        run_until(b + 1, 100);
        drain();
        chk("post_wd_res", q_res[b], 24); chk("post_wd_lat", q_lat[b], 4);
        b = q_id.size(); force_n0 = 6; force_d = T - 1; allow0 = 1;
        run_until(b + 1, 200);
        drain();
        chk("edge_res", q_res[b], 720); chk("edge_flags", {q_err[b], q_to[b]}, 0);
        chk("edge_lat", q_lat[b], 65);

        // Reset in the middle of BUSY abandons the transaction.
        force_n0 = 7; force_d = 20; allow0 = 1;
        for (int i = 0; i < 20 && !(in_txn && cyc >= go_cyc + 3); i++) step();
        chk("pre_rst_busy", busy, 1);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_out", {ack0, ack1, gnt_id, fact_go, result}, 0);
        allow0 = 0; req0 = 0; req1 = 0; fact_done = 0;
        model_reset();
        @(negedge CLK);
        RST = 1'b0;
        b = q_id.size(); stray = 1; force_d = -1;
        repeat (12) step();
        chk("stray_noack", q_id.size(), b);

        // Pointer back at 0 after reset.
        b = q_id.size(); force_n0 = 2; force_n1 = 6; allow0 = 1; allow1 = 1;
        run_until(b + 2, 200);
        drain();
        chk("rtie_id0", q_id[b], 0);   chk("rtie_res0", q_res[b], 2);
        chk("rtie_id1", q_id[b+1], 1); chk("rtie_res1", q_res[b+1], 720);

        // Random traffic with stray done pulses.
        force_n0 = -1; force_n1 = -1; force_d = -1; p_req = 30; p_rereq = 50;
        allow0 = 1; allow1 = 1;
        repeat (3000) step();
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fact_arbiter.md
Name: fact_arbiter

Overview:
Two-requester round-robin scheduler that shares the single factorial engine (control unit plus datapath) in the SoC.
- Latches the winning requester's operand n.
- Issues a one-cycle go pulse to the engine, waits for its done pulse, and returns result/error to the granted requester with a one-cycle ack.
- A watchdog counter guarantees every request is answered even if the engine hangs.

Parameters:
- N_W, 4, operand width (n = 0..15).
- RES_W, 32, result width.
- TIMEOUT_CYCLES, 64, max cycles in BUSY before forced completion (must be >= 2).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- req0  in  1  requester 0 request; held high until ack0.
- n0  in  N_W  requester 0 operand; stable while req0 is high.
- req1  in  1  requester 1 request; held high until ack1.
- n1  in  N_W  requester 1 operand.
- ack0  out  1  one-cycle pulse: requester 0 transaction complete.
- ack1  out  1  one-cycle pulse: requester 1 transaction complete.
- result  out  RES_W  factorial result; valid in the ack cycle, held until next ack.
- error  out  1  engine error flag; valid with ack.
- timeout  out  1  watchdog expired; valid with ack.
- busy  out  1  high in every state except IDLE.
- gnt_id  out  1  id of the currently or most recently granted requester.
- fact_go  out  1  go pulse to the engine.
- fact_n  out  N_W  operand to the engine; registered.
- fact_done  in  1  engine done pulse.
- fact_error  in  1  engine error, sampled with fact_done.
- fact_result  in  RES_W  engine result, sampled with fact_done.

Behaviour:
- Reset (RST=1, asynchronous): state=IDLE, priority pointer=0, all outputs 0 (ack0/1, result, error, timeout, busy, gnt_id, fact_go, fact_n), watchdog=0. Reset mid-transaction abandons it with no ack; the engine shares RST.
- FSM states: IDLE, ISSUE, BUSY, RESP; one transaction at a time, no queueing.
- IDLE:
  - No request: stay.
  - One request: grant it.
  - Both requests: grant the requester equal to the priority pointer.
  - On grant: latch gnt_id; latch fact_n from n0/n1; clear error/timeout; go to ISSUE.
- ISSUE: fact_go=1 for exactly this cycle; watchdog=0; go to BUSY.
- BUSY:
  - Watchdog increments each cycle.
  - On fact_done=1: latch result=fact_result, error=fact_error, timeout=0; go to RESP.
  - Else, when watchdog==TIMEOUT_CYCLES-1: result=0, error=1, timeout=1; go to RESP.
  - fact_done in the same cycle as expiry: done wins, timeout=0.
- RESP:
  - Pulse ack[gnt_id]=1 for one cycle.
  - Pointer = ~gnt_id, so the other requester wins the next tie.
  - Go to IDLE.
- Any fact_done outside BUSY is ignored.
- Requester rule: drop req on the edge after its ack. A req still high in the next IDLE cycle counts as a new request.
- Requests are not sampled in ISSUE/BUSY/RESP. A request arriving then waits in IDLE; the pointer still provides fairness.
- Latency: req high in IDLE cycle t, then fact_go at t+1. Ack comes one cycle after the cycle fact_done is sampled. Minimum IDLE-to-IDLE time = engine latency + 3 cycles.
- result/error/timeout keep their values after ack until the next transaction's completion.
- busy = (state != IDLE); registered from state.
- Range checking (n > 12 overflows RES_W) belongs to the engine; error passes through unmodified.

Test Plan:
- Single request: req0=1, n0=5, real engine -> one fact_go pulse with fact_n=5; ack0 pulse; result=120, error=0, timeout=0; ack1 never asserted.
- Tie after reset: req0 and req1 asserted in the same cycle, n0=3, n1=4 -> ack0 with result=6 first, then ack1 with result=24; gnt_id 0 then 1.
- Fairness: both requesters re-request immediately after every ack for 6 transactions -> grants strictly alternate 0,1,0,1,0,1.
- Engine error: req1=1, n1=13 with engine flagging error -> ack1, error=1, timeout=0.
- Watchdog: stub engine never asserts fact_done, TIMEOUT_CYCLES=64 -> ack exactly 64 cycles after entering BUSY; result=0, error=1, timeout=1; next request is serviced normally.
- Reset mid-BUSY: assert RST during BUSY -> immediately state=IDLE, busy=0, no ack, pointer=0. Stray fact_done pulses after reset produce no ack.
